// File: rtl/sp_enc_pkg.sv
// Shared widths for the 32-to-5 round-robin request encoder.
package sp_enc_pkg;
    localparam int unsigned SP_REQ_W = 32;
    localparam int unsigned SP_IDX_W = 5;
    localparam int unsigned SP_CNT_W = 6;
endpackage

// File: rtl/sp_32_5_rr_pick.sv
// Rotating priority find: first set bit of pending at or after ptr, wrapping mod 32.
module sp_32_5_rr_pick
    import sp_enc_pkg::*;
(
    input  logic [SP_REQ_W-1:0] pending,
    input  logic [SP_IDX_W-1:0] ptr,
    output logic [SP_IDX_W-1:0] pick,
    output logic                has_pick
);

    logic [SP_REQ_W-1:0] rot;
    logic [SP_IDX_W-1:0] off;

    // Rotate so bit 0 of rot is pending[ptr], then take the lowest set offset.
    always_comb begin
        rot = SP_REQ_W'({pending, pending} >> ptr);
        off = '0;
        for (int i = SP_REQ_W - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SP_IDX_W'(i);
            end
        end
        pick     = off + ptr;
        has_pick = |pending;
    end

endmodule

// File: rtl/sp_32_5_rr_encode.sv
// Round-robin 32-to-5 encoder: captures active-low requests, emits one index per handshake.
module sp_32_5_rr_encode
    import sp_enc_pkg::*;
#(
    parameter int unsigned RESET_PTR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SP_REQ_W-1:0] req_b,
    input  logic                load,
    output logic [SP_IDX_W-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic [SP_CNT_W-1:0] pend_cnt
);

    logic [SP_REQ_W-1:0] pending;
    logic [SP_REQ_W-1:0] pend_nxt;
    logic [SP_REQ_W-1:0] cap;
    logic [SP_IDX_W-1:0] ptr;
    logic [SP_IDX_W-1:0] pick;
    logic                has_pick;
    logic                advance;
    logic                take;

    sp_32_5_rr_pick u_pick (
        .pending  (pending),
        .ptr      (ptr),
        .pick     (pick),
        .has_pick (has_pick)
    );

    // A capture on the picking edge wins over the clear, so the index is serviced again.
    always_comb begin
        cap      = load ? ~req_b : '0;
        advance  = !out_valid || out_ready;
        take     = advance && has_pick;
        pend_nxt = (pending & ~(take ? (SP_REQ_W'(1) << pick) : '0)) | cap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            ptr       <= SP_IDX_W'(RESET_PTR);
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (advance) begin
                out_valid <= has_pick;
                if (has_pick) begin
                    out <= pick;
                    ptr <= pick + SP_IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < SP_REQ_W; i++) begin
            pend_cnt = pend_cnt + SP_CNT_W'(pending[i]);
        end
        busy = (|pending) || out_valid;
    end

endmodule

// File: tb/tb_sp_32_5_rr_encode.sv
// Scoreboard bench for sp_32_5_rr_encode against a set-based round-robin reference model.
module tb_sp_32_5_rr_encode;

    logic        clk;
    logic        reset;
    logic [31:0] req_b;
    logic        load;
    logic [4:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [5:0]  pend_cnt;

    int n_cmp = 0;
    int n_err = 0;

    sp_32_5_rr_encode #(.RESET_PTR(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_b     (req_b),
        .load      (load),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .pend_cnt  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending as a plain bit set, pointer as an integer index.
    bit [31:0] m_pend;
    int        m_ptr;
    bit        m_ov;
    int        m_out;
    int        exp_q[$];
    int        acc_log[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int popc(input bit [31:0] v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_ptr  = 0;
        m_ov   = 1'b0;
        m_out  = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit ld, input bit [31:0] rb, input bit rdy);
        bit [31:0] cap;
        int found;
        cap   = ld ? ~rb : 32'h0;
        found = -1;
        if (!m_ov || rdy) begin
            for (int k = 0; k < 32; k++) begin
                if (found < 0 && m_pend[(m_ptr + k) % 32]) found = (m_ptr + k) % 32;
            end
            if (found >= 0) begin
                m_pend[found] = 1'b0;
                m_out = found;
                m_ov  = 1'b1;
                m_ptr = (found + 1) % 32;
                exp_q.push_back(found);
            end else begin
                m_ov = 1'b0;
            end
        end
        m_pend = m_pend | cap;
    endtask

    // One clock: drive inputs, step the model on the edge, check state after the edge.
    task automatic cycle(input bit ld, input bit [31:0] rb, input bit rdy);
        load      = ld;
        req_b     = rb;
        out_ready = rdy;
        @(posedge clk);
        model_step(ld, rb, rdy);
        @(negedge clk);
        #1;
        chk("out_valid", int'(out_valid), int'(m_ov));
        chk("pend_cnt", int'(pend_cnt), popc(m_pend));
        chk("busy", int'(busy), int'((m_pend != 0) || m_ov));
        if (m_ov) chk("out_held", int'(out), m_out);
    endtask

    task automatic drain();
        int n = 0;
        while ((m_ov || m_pend != 0) && n < 200) begin
            cycle(1'b0, 32'hFFFF_FFFF, 1'b1);
            n++;
        end
        chk("drain_bound", int'(n < 200), 1);
    endtask

    task automatic check_log(input string nm, input int e[$]);
        chk({nm, "_len"}, acc_log.size(), e.size());
        for (int i = 0; i < e.size() && i < acc_log.size(); i++) chk(nm, acc_log[i], e[i]);
    endtask

    // Monitor: just before each edge, an accepted output must match the next expected index.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got %0d expected none at %0t", out, $time);
                end else begin
                    chk("sb_out", int'(out), exp_q.pop_front());
                end
                acc_log.push_back(int'(out));
            end
        end
    end

    initial begin
        int e[$];
        int sevens;
        bit [31:0] rb;

        reset     = 1'b1;
        load      = 1'b0;
        req_b     = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(pend_cnt), 0);
        reset = 1'b0;

        // All 32 requests in one load: indices 0..31 back to back.
        acc_log.delete();
        cycle(1'b1, 32'h0, 1'b1);
        chk("full_cnt", int'(pend_cnt), 32);
        drain();
        e.delete();
        for (int i = 0; i < 32; i++) e.push_back(i);
        check_log("all_seq", e);

        // Backpressure: {2,9} pending, stall, capture 4 mid-stall, then release.
        acc_log.delete();
        cycle(1'b1, ~(32'h4 | 32'h200), 1'b0);
        cycle(1'b0, 32'hFFFF_FFFF, 1'b0);
        chk("bp_cnt1", int'(pend_cnt), 1);
        cycle(1'b0, 32'hFFFF_FFFF, 1'b0);
        cycle(1'b1, ~32'h10, 1'b0);
        chk("bp_cnt2", int'(pend_cnt), 2);
        cycle(1'b0, 32'hFFFF_FFFF, 1'b0);
        chk("bp_out", int'(out), 2);
        drain();
        e = {2, 4, 9};
        check_log("bp_seq", e);

        // Single request on index 5.
        acc_log.delete();
        cycle(1'b1, 32'hFFFF_FFDF, 1'b1);
        drain();
        e = {5};
        check_log("single", e);

        // Wrap-around: put ptr at 30 via index 29, then {3,31}.
        cycle(1'b1, ~(32'h1 << 29), 1'b1);
        drain();
        acc_log.delete();
        cycle(1'b1, ~(32'h8 | 32'h8000_0000), 1'b1);
        drain();
        e = {31, 3};
        check_log("wrap", e);

        // Capture of 7 on the edge that picks 7: presented twice.
        acc_log.delete();
        cycle(1'b1, ~32'h80, 1'b1);
        cycle(1'b1, ~32'h80, 1'b1);
        drain();
        sevens = 0;
        foreach (acc_log[i]) if (acc_log[i] == 7) sevens++;
        chk("sevens", sevens, 2);

        // Asynchronous reset with out_valid=1 and pending=0x00F0.
        cycle(1'b1, ~32'hF4, 1'b0);
        cycle(1'b0, 32'hFFFF_FFFF, 1'b0);
        chk("pre_rst_cnt", int'(pend_cnt), 4);
        #2 reset = 1'b1;
        #1;
        chk("arst_out", int'(out), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_cnt", int'(pend_cnt), 0);
        model_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        acc_log.delete();
        cycle(1'b1, ~(32'h2 | 32'h0010_0000), 1'b1);
        drain();
        e = {1, 20};
        check_log("post_rst", e);

        // Randomized traffic with sparse requests and random backpressure.
        for (int i = 0; i < 400; i++) begin
            rb = ~($urandom() & $urandom() & $urandom());
            cycle(($urandom() % 4) == 0, rb, ($urandom() % 10) < 7);
        end
        drain();
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
